// File: rtl/symbol_seq_pkg.sv
// Shared types and constants for the symbol sequencer.
package symbol_seq_pkg;
    localparam int SYM_W        = 4;
    localparam int WORD_W       = 32;
    localparam int LANE_SEL_W   = 2;
    localparam int SYM_PER_WORD = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/symbol_sequencer_byte_lane_mux.sv
// Selects one byte lane of a 32-bit word.
module byte_lane_mux
    import symbol_seq_pkg::*;
(
    input  logic [WORD_W-1:0]     word,
    input  logic [LANE_SEL_W-1:0] sel,
    output logic [7:0]            lane
);
    assign lane = word[{sel, 3'b000} +: 8];
endmodule

// File: rtl/symbol_sequencer.sv
// Splits 32-bit words into eight 4-bit symbols, low nibble of byte 0 first, with optional pacing.
// Optional accepted-symbol counter enabled by SEQ_CNT_EN.
module symbol_sequencer
    import symbol_seq_pkg::*;
#(
    parameter int SYM_PERIOD = 1
`ifdef SEQ_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              inClk,
    input  logic              inRst,
    input  logic              inValid,
    input  logic [WORD_W-1:0] inWord,
    output logic              outReady,
    output logic              outSymValid,
    output logic [SYM_W-1:0]  outSym,
    output logic              outLast,
    input  logic              inSymReady,
    output logic              outBusy
`ifdef SEQ_CNT_EN
    ,
    output logic [CNT_W-1:0]  outSymCnt
`endif
);
    localparam logic [7:0] GAP_LOAD = 8'(SYM_PERIOD - 1);

    state_t                state;
    logic [WORD_W-1:0]     word;
    logic [LANE_SEL_W-1:0] idx;
    logic                  nib;
    logic [7:0]            cnt;
    logic [7:0]            lane;
    logic                  is_last;

    byte_lane_mux u_mux (
        .word (word),
        .sel  (idx),
        .lane (lane)
    );

    assign is_last     = (idx == 2'd3) && nib;
    assign outReady    = (state == IDLE);
    assign outBusy     = (state != IDLE);
    assign outSymValid = (state == EMIT);
    assign outLast     = (state == EMIT) && is_last;
    // Symbol is forced to zero outside EMIT so idle/gap cycles show a clean bus.
    assign outSym      = (state == EMIT) ? (nib ? lane[7:4] : lane[3:0]) : '0;

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
            nib   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        word  <= inWord;
                        idx   <= '0;
                        nib   <= 1'b0;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (inSymReady) begin
                        if (is_last) begin
                            state <= IDLE;
                        end else begin
                            {idx, nib} <= {idx, nib} + 3'd1;
                            if (SYM_PERIOD > 1) begin
                                state <= GAP;
                                cnt   <= GAP_LOAD;
                            end
                        end
                    end
                end
                GAP: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= EMIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_CNT_EN
    logic [CNT_W-1:0] sym_cnt;

    always_ff @(posedge inClk) begin
        if (inRst)                          sym_cnt <= '0;
        else if (outSymValid && inSymReady) sym_cnt <= sym_cnt + 1'b1;
    end

    assign outSymCnt = sym_cnt;
`endif
endmodule
